// File: rtl/cache_refill_ctrl_pkg.sv
// Shared widths, refill FSM state type and address field helpers for the L1D miss handler.
package cache_pkg;

  localparam int TAG_W   = 19;
  localparam int IDX_W   = 7;
  localparam int OFF_W   = 6;
  localparam int LINE_W  = 512;
  localparam int WAYS    = 4;
  localparam int WORD_W  = 32;
  localparam int PADDR_W = TAG_W + IDX_W + OFF_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    BEAT = 3'd2,
    FILL = 3'd3,
    RESP = 3'd4
  } refill_state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [PADDR_W-1:0] a);
    return a[PADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [PADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_offset(input logic [PADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction

  // Lowest-index invalid way wins; a full set falls back to the random pick.
  function automatic logic [1:0] pick_victim(input logic [WAYS-1:0] vld,
                                             input logic [1:0]      rnd);
    logic [1:0] w_sel;
    w_sel = rnd;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!vld[w]) w_sel = 2'(w);
    end
    return w_sel;
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Miss / memory / fill / response signal bundle between the L1D, main memory and the refill controller.
interface cache_refill_if;
  import cache_pkg::*;

  logic                 miss_valid;
  logic                 miss_ready;
  logic [WORD_W-1:0]    miss_pc;
  logic [PADDR_W-1:0]   miss_addr;
  logic                 miss_is_store;
  logic                 miss_store_size;
  logic [WORD_W-1:0]    miss_store_data;
  logic [WAYS-1:0]      way_valid;

  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic [PADDR_W-1:0]   mem_req_addr;
  logic                 mem_rdata_valid;
  logic [WORD_W-1:0]    mem_rdata;

  logic                 fill_valid;
  logic [IDX_W-1:0]     fill_index;
  logic [TAG_W-1:0]     fill_tag;
  logic [1:0]           fill_way;
  logic [LINE_W-1:0]    fill_data;

  logic                 resp_valid;
  logic                 resp_ready;
  logic [WORD_W-1:0]    resp_pc;
  logic [WORD_W-1:0]    resp_data;

  logic                 busy;

  // Controller side
  modport slave (
    input  miss_valid, miss_pc, miss_addr, miss_is_store, miss_store_size,
           miss_store_data, way_valid, mem_req_ready, mem_rdata_valid, mem_rdata,
           resp_ready,
    output miss_ready, mem_req_valid, mem_req_addr, fill_valid, fill_index,
           fill_tag, fill_way, fill_data, resp_valid, resp_pc, resp_data, busy
  );

  // Cache / memory / LSQ side
  modport master (
    output miss_valid, miss_pc, miss_addr, miss_is_store, miss_store_size,
           miss_store_data, way_valid, mem_req_ready, mem_rdata_valid, mem_rdata,
           resp_ready,
    input  miss_ready, mem_req_valid, mem_req_addr, fill_valid, fill_index,
           fill_tag, fill_way, fill_data, resp_valid, resp_pc, resp_data, busy
  );

endinterface

// File: rtl/cache_refill_ctrl_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used as the random victim source for full sets.
module refill_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] lfsr_lo
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (en) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign lfsr_lo = lfsr_q[1:0];

endmodule

// File: rtl/cache_refill_ctrl.sv
// Single-outstanding L1D miss handler: fetches a 16-beat line, merges store data,
// writes the line back to a victim way and returns the load word to the LSQ.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter int         BEATS     = 16,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic           clk,
  input logic           rst,
  cache_refill_if.slave bus
);

  localparam int                CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  refill_state_t        state;
  logic [CNT_W-1:0]     beat_cnt;
  logic [OFF_W-1:0]     off_q;
  logic [WORD_W-1:0]    pc_q;
  logic                 st_q;
  logic                 sz_q;
  logic [15:0]          sd_q;
  logic [LINE_W-1:0]    line_q;
  logic [LINE_W-1:0]    line_nxt;
  logic [ADDR_W-1:0]    req_addr_nxt;
  logic [1:0]           lfsr_lo;

  refill_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en      (1'b1),
    .lfsr_lo (lfsr_lo)
  );

  assign req_addr_nxt = {bus.miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Complete line as it will look after the final beat, with the store bytes overlaid.
  always_comb begin
    line_nxt = line_q;
    line_nxt[{beat_cnt, 5'd0} +: WORD_W] = bus.mem_rdata;
    if (st_q) begin
      if (sz_q) line_nxt[{off_q, 3'd0} +: 8]       = sd_q[7:0];
      else      line_nxt[{off_q[5:1], 4'd0} +: 16] = sd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      beat_cnt            <= '0;
      off_q               <= '0;
      pc_q                <= '0;
      st_q                <= 1'b0;
      sz_q                <= 1'b0;
      sd_q                <= '0;
      line_q              <= '0;
      bus.miss_ready      <= 1'b1;
      bus.mem_req_valid   <= 1'b0;
      bus.mem_req_addr    <= '0;
      bus.fill_valid      <= 1'b0;
      bus.fill_index      <= '0;
      bus.fill_tag        <= '0;
      bus.fill_way        <= '0;
      bus.fill_data       <= '0;
      bus.resp_valid      <= 1'b0;
      bus.resp_pc         <= '0;
      bus.resp_data       <= '0;
      bus.busy            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.miss_valid && bus.miss_ready) begin
            off_q             <= addr_offset(bus.miss_addr);
            pc_q              <= bus.miss_pc;
            st_q              <= bus.miss_is_store;
            sz_q              <= bus.miss_store_size;
            sd_q              <= bus.miss_store_data[15:0];
            beat_cnt          <= '0;
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_addr  <= req_addr_nxt;
            // Index/tag go out early so the cache can present way_valid for this set.
            bus.fill_index    <= addr_index(bus.miss_addr);
            bus.fill_tag      <= addr_tag(bus.miss_addr);
            bus.miss_ready    <= 1'b0;
            bus.busy          <= 1'b1;
            state             <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= BEAT;
          end
        end
        BEAT: begin
          if (bus.mem_rdata_valid) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt       <= '0;
              bus.fill_data  <= line_nxt;
              bus.fill_way   <= pick_victim(bus.way_valid, lfsr_lo);
              bus.fill_valid <= 1'b1;
              state          <= FILL;
            end else begin
              line_q[{beat_cnt, 5'd0} +: WORD_W] <= bus.mem_rdata;
              beat_cnt                           <= beat_cnt + CNT_W'(1);
            end
          end
        end
        FILL: begin
          bus.fill_valid <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_pc    <= pc_q;
          bus.resp_data  <= st_q ? '0 : bus.fill_data[{off_q[5:2], 5'd0} +: WORD_W];
          state          <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.miss_ready <= 1'b1;
            bus.busy       <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
